// File: rtl/stft_pkg.sv
// rtl/stft_pkg.sv - shared FSM encodings and checksum width for the STFT datapath.
package stft_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int CSUM_WIDTH = 32;

endpackage

// File: rtl/twiddle_ram.sv
// rtl/twiddle_ram.sv - N x 2*word_size table, synchronous write, asynchronous read.
module twiddle_ram #(
  parameter int N         = 32,
  parameter int word_size = 16
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [$clog2(N)-1:0]   waddr,
  input  logic [2*word_size-1:0] wdata,
  input  logic [$clog2(N)-1:0]   read_address,
  output logic [2*word_size-1:0] twiddle
);

  // Storage is deliberately not reset; contents are defined by the first load.
  logic [2*word_size-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign twiddle = mem_q[read_address];

endmodule

// File: rtl/twiddle_loader.sv
// rtl/twiddle_loader.sv - streams a twiddle table into twiddle_ram; optional XOR trailer check via TWIDDLE_LOADER_CHECKSUM_EN.
module twiddle_loader #(
  parameter int N         = 32,
  parameter int word_size = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   s_valid,
  input  logic [2*word_size-1:0] s_data,
  output logic                   s_ready,
  input  logic [$clog2(N)-1:0]   read_address,
  output logic [2*word_size-1:0] twiddle,
  output logic                   loading,
  output logic                   done,
  output logic                   error
);
  import stft_pkg::*;

  localparam int AW = $clog2(N);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          done_q, done_d;
  logic          xfer;
  logic          we;
  logic          last_word;

  assign s_ready   = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign loading   = s_ready;
  assign done      = done_q;
  assign xfer      = s_valid && s_ready;
  assign last_word = (wr_ptr_q == AW'(N - 1));
  // A start in the same cycle as a transfer wins; the word is dropped.
  assign we        = xfer && (state_q == ST_LOAD) && !start;

`ifdef TWIDDLE_LOADER_CHECKSUM_EN
  logic [CSUM_WIDTH-1:0] acc_q, acc_d;
  logic                  error_q, error_d;

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    done_d   = done_q;
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    acc_d    = acc_q;
    error_d  = error_q;
`endif
    if (start) begin
      state_d  = ST_LOAD;
      wr_ptr_d = '0;
      done_d   = 1'b0;
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
      acc_d    = '0;
      error_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (xfer) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
            acc_d = acc_q ^ CSUM_WIDTH'(s_data);
            if (last_word) begin
              state_d = ST_CHECK;
            end
`else
            if (last_word) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
`endif
          end
        end
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (xfer) begin
            error_d = (CSUM_WIDTH'(s_data) != acc_q);
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      done_q   <= 1'b0;
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
      acc_q    <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      done_q   <= done_d;
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
      acc_q    <= acc_d;
      error_q  <= error_d;
`endif
    end
  end

  twiddle_ram #(
    .N         (N),
    .word_size (word_size)
  ) u_ram (
    .clk          (clk),
    .we           (we),
    .waddr        (wr_ptr_q),
    .wdata        (s_data),
    .read_address (read_address),
    .twiddle      (twiddle)
  );

endmodule

// File: tb/tb_twiddle_loader.sv
// tb/tb_twiddle_loader.sv - scoreboard bench for twiddle_loader (N=32, word_size=16).
module tb_twiddle_loader;

  localparam int N = 32;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          s_valid;
  logic [2*W-1:0] s_data;
  logic          s_ready;
  logic [4:0]    read_address;
  logic [2*W-1:0] twiddle;
  logic          loading;
  logic          done;
  logic          error;

  twiddle_loader #(.N(N), .word_size(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .read_address (read_address),
    .twiddle      (twiddle),
    .loading      (loading),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } sb_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_tab [N];
  int          mptr;
  logic [31:0] csum_m;
  sb_t         sb_q [$];
  int          done_rises = 0;
  logic        done_prev = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1 && done_prev !== 1'b1) done_rises++;
    done_prev = done;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    mptr   = 0;
    csum_m = '0;
    sb_q.delete();
  endtask

  // One handshake; the model is updated only if the DUT accepted the word.
  task automatic xfer(input logic [31:0] d, input bit gap);
    bit ok;
    ok = 1'b0;
    if (gap) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    for (int c = 0; c < 20 && !ok; c++) begin
      ok = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL xfer_timeout: s_ready=0 required 1");
    end else begin
      exp_tab[mptr] = d;
      sb_q.push_back('{mptr, d});
      mptr++;
      csum_m ^= d;
    end
  endtask

`ifdef TWIDDLE_LOADER_CHECKSUM_EN
  task automatic trailer(input logic [31:0] flip);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = csum_m ^ flip;
    for (int c = 0; c < 20 && !ok; c++) begin
      ok = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask
`endif

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; read_address = '0;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    if (loading !== 1'b0) begin errors++; $display("FAIL reset_loading: got %b want 0", loading); end
    if (done    !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    if (error   !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL idle_s_ready: got %b want 0", s_ready); end
  endtask

  task automatic test_full_load();
    pulse_start();
    checks++;
    if (loading !== 1'b1) begin errors++; $display("FAIL full_loading: got %b want 1", loading); end
    for (int i = 0; i < N; i++) begin
      xfer(32'h0001_0000 + i, 1'b0);
      if (i == N - 2) begin
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL full_done_early: got %b want 0", done); end
      end
    end
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    trailer(32'h0);
`endif
    checks += 2;
    if (done !== 1'b1)    begin errors++; $display("FAIL full_done: got %b want 1", done); end
    if (loading !== 1'b0) begin errors++; $display("FAIL full_loading_end: got %b want 0", loading); end
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL done_s_ready: got %b want 0", s_ready); end
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b0;
    read_address = 5'd5;
    #1;
    checks++;
    if (twiddle !== 32'h0001_0005) begin errors++; $display("FAIL full_addr5: got %h want 00010005", twiddle); end
    while (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      read_address = e.addr[4:0];
      #1;
      checks++;
      if (twiddle !== e.data) begin errors++; $display("FAIL full_entry[%0d]: got %h want %h", e.addr, twiddle, e.data); end
    end
  endtask

  task automatic test_backpressure();
    pulse_start();
    for (int i = 0; i < N; i++) begin
      xfer(32'h0002_0000 + 32'(i * 7), ($urandom_range(0, 2) == 0));
      if (i < N - 1) begin
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL bp_done_early[%0d]: got %b want 0", i, done); end
      end
    end
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    trailer(32'h0);
`endif
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", done); end
    while (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      read_address = e.addr[4:0];
      #1;
      checks++;
      if (twiddle !== e.data) begin errors++; $display("FAIL bp_entry[%0d]: got %h want %h", e.addr, twiddle, e.data); end
    end
  endtask

  task automatic test_abort();
    int rises0;
    pulse_start();
    for (int i = 0; i < 10; i++) xfer(32'h0001_0000 + i, 1'b0);
    start   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    start   = 1'b0;
    s_valid = 1'b0;
    mptr    = 0;
    csum_m  = '0;
    sb_q.delete();
    rises0  = done_rises;
    for (int i = 0; i < N; i++) xfer(32'hFFFF_0000 + i, 1'b0);
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    trailer(32'h0);
`endif
    repeat (3) @(posedge clk);
    #1;
    checks += 2;
    if (done !== 1'b1) begin errors++; $display("FAIL abort_done: got %b want 1", done); end
    if (done_rises - rises0 != 1) begin errors++; $display("FAIL abort_done_once: got %0d rises want 1", done_rises - rises0); end
    while (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      read_address = e.addr[4:0];
      #1;
      checks++;
      if (twiddle !== e.data) begin errors++; $display("FAIL abort_entry[%0d]: got %h want %h", e.addr, twiddle, e.data); end
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    for (int i = 0; i < 16; i++) xfer(32'h1234_0000 + i, 1'b0);
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_s_ready: got %b want 0", s_ready); end
    if (loading !== 1'b0) begin errors++; $display("FAIL rst_mid_loading: got %b want 0", loading); end
    if (done    !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", done); end
    @(posedge clk); #1;
    rst_n   = 1'b1;
    mptr    = 0;
    csum_m  = '0;
    s_valid = 1'b1;
    s_data  = 32'h0BAD_0BAD;
    repeat (4) @(posedge clk);
    #1;
    checks += 2;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_idle_s_ready: got %b want 0", s_ready); end
    if (done    !== 1'b0) begin errors++; $display("FAIL rst_idle_done: got %b want 0", done); end
    s_valid = 1'b0;
    for (int a = 16; a < N; a++) sb_q.push_back('{a, exp_tab[a]});
    while (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      read_address = e.addr[4:0];
      #1;
      checks++;
      if (twiddle !== e.data) begin errors++; $display("FAIL rst_entry[%0d]: got %h want %h", e.addr, twiddle, e.data); end
    end
  endtask

  task automatic test_reload();
    pulse_start();
    for (int i = 0; i < N; i++) xfer(32'h0030_0000 + i, 1'b0);
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    trailer(32'h0);
`endif
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL reload_first_done: got %b want 1", done); end
    pulse_start();
    checks += 2;
    if (done    !== 1'b0) begin errors++; $display("FAIL reload_done_drop: got %b want 0", done); end
    if (loading !== 1'b1) begin errors++; $display("FAIL reload_loading: got %b want 1", loading); end
    for (int i = 0; i < N; i++) xfer(32'h0040_0000 + 32'(i * 3), 1'b0);
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    trailer(32'h0);
`endif
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL reload_done: got %b want 1", done); end
    while (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      read_address = e.addr[4:0];
      #1;
      checks++;
      if (twiddle !== e.data) begin errors++; $display("FAIL reload_entry[%0d]: got %h want %h", e.addr, twiddle, e.data); end
    end
  endtask

`ifdef TWIDDLE_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    for (int i = 0; i < N; i++) xfer($urandom, 1'b0);
    trailer(32'h0);
    checks += 2;
    if (error !== 1'b0) begin errors++; $display("FAIL csum_good_error: got %b want 0", error); end
    if (done  !== 1'b1) begin errors++; $display("FAIL csum_good_done: got %b want 1", done); end
    while (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      read_address = e.addr[4:0];
      #1;
      checks++;
      if (twiddle !== e.data) begin errors++; $display("FAIL csum_entry[%0d]: got %h want %h", e.addr, twiddle, e.data); end
    end
    pulse_start();
    for (int i = 0; i < N; i++) xfer($urandom, 1'b0);
    trailer(32'h1);
    checks += 2;
    if (error !== 1'b1) begin errors++; $display("FAIL csum_bad_error: got %b want 1", error); end
    if (done  !== 1'b1) begin errors++; $display("FAIL csum_bad_done: got %b want 1", done); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_backpressure();
    test_abort();
    test_reset_mid_load();
    test_reload();
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
